// File: rtl/ap_sat_accum.sv
// Saturating signed frame accumulator: sums +/- beats per frame and hands off a clamped result.
// Optional per-frame clamp counter output sat_cnt is enabled with `define AP_SAT_ACCUM_SATCNT_EN.
module ap_sat_accum #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_sub,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
`ifdef AP_SAT_ACCUM_SATCNT_EN
  output logic [7:0]              sat_cnt,
`endif
  output logic                    out_sat
);

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    accept;
  logic signed [WIDTH:0]   sum;
  logic                    ovf;
  logic signed [WIDTH-1:0] step_val;

  // One extra bit holds any single add/sub exactly; disagreement of the top two bits means clamp.
  always_comb begin
    sum      = in_sub ? ({acc_q[WIDTH-1], acc_q} - {in_data[WIDTH-1], in_data})
                      : ({acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data});
    ovf      = sum[WIDTH] ^ sum[WIDTH-1];
    step_val = ovf ? (sum[WIDTH] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACC: if (accept) begin
          acc_d = step_val;
          sat_d = sat_q | ovf;
          if (in_last) state_d = DONE;
        end
        DONE: if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ACC) && !clr;
    out_valid = (state_q == DONE);
    out_data  = acc_q;
    out_sat   = sat_q;
  end

`ifdef AP_SAT_ACCUM_SATCNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Cleared on exactly the same events as the sticky bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (state_q == DONE && out_ready)) cnt_d = '0;
    else if (accept && ovf && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_cnt = cnt_q;
`endif

endmodule
